pushbutton_debounce: RTL
========================

# pushbutton_debounce

Synchronises and debounces the raw, active-low KEY[3:0] pushbutton pins and drives clean, glitch-free levels into the pushbutton PIO's `in_port`. It sits between the board pins and the PIO slave. The PIO's two-flop falling-edge capture then sees exactly one edge per physical press. Each channel runs its own synchroniser, its own stability counter and its own 2-state FSM, with no interaction between channels.

## Interface
- `WIDTH`, 4: number of button channels.
- `CNT_MAX`, 500000: number of consecutive clocks the synchronised input must differ from the output before the output follows it (10 ms at 50 MHz). Legal range is ≥ 1.
- `SYNC_STAGES`, 2: depth of the input synchroniser. Legal range is ≥ 2.

Ports (reset is asynchronous, active-low `reset_n`; clock is `clk`):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_raw`  in  WIDTH  raw pin levels; asynchronous, bouncing, active-low (0 = pressed).
- `db_out`  out  WIDTH  debounced level with the same polarity as `in_raw`; connects to PIO `in_port`.
- `press_pulse`  out  WIDTH  one-clock pulse per debounced press. Present only with `PB_DEBOUNCE_EVENT_EN`.
- `release_pulse`  out  WIDTH  one-clock pulse per debounced release. Present only with `PB_DEBOUNCE_EVENT_EN`.

## Operation
- **Synchroniser:** a SYNC_STAGES-deep flop chain per bit. It resets to all-ones (released). `sync[i]` is the last stage.
- **Per-channel FSM states:**
  - STABLE: `sync == db_out`; `cnt` is held at 0.
  - PENDING: `sync != db_out`; `cnt` counts.
- **Transitions, evaluated each clock:**
  - STABLE → PENDING when `sync != db_out`; `cnt <= 1`. If CNT_MAX == 1, `db_out <= sync` immediately and the state stays STABLE.
  - PENDING → STABLE when `sync == db_out` (bounce back); `cnt <= 0` and `db_out` is unchanged.
  - PENDING with `cnt == CNT_MAX-1` and `sync` still differing: `db_out <= sync`, `cnt <= 0`, state → STABLE.
  - Otherwise in PENDING: `cnt <= cnt+1`.
- **Counter:** width is `$clog2(CNT_MAX+1)`. It never exceeds CNT_MAX-1, so it cannot wrap.
- **Bounce handling:** any return to the old level restarts qualification from zero. There is no hysteresis beyond this.
- **Channel independence:** channels are fully independent. Simultaneous presses on several channels each qualify on their own counters.
- **Reset:** asserting `reset_n` at any time, including mid-PENDING, forces the following immediately. After release, a held-down button needs the full latency before `db_out` falls.
  - sync flops = 1
  - `db_out` = all-ones
  - `cnt` = 0
  - state = STABLE
  - pulses = 0

## Timing
- **Reset values:**
  - `db_out` = {WIDTH{1'b1}}
  - `press_pulse` = 0
  - `release_pulse` = 0
- **Latency:** a pin change first sampled at edge k reaches `sync` at edge k+SYNC_STAGES-1. `db_out` updates at edge k+SYNC_STAGES-1+CNT_MAX, provided the level holds throughout.
- **Glitch rejection:** a change lasting fewer than CNT_MAX synchronised clocks never reaches `db_out`.
- **Registered outputs:** `db_out` and both pulses are registered. No combinational path exists from `in_raw`.
- **Pulse timing:** `press_pulse[i]` is high for exactly one clock, on the cycle after `db_out[i]` falls 1→0. `release_pulse[i]` behaves the same way on a 0→1 rise.

## Configuration
- **Macro:** `PB_DEBOUNCE_EVENT_EN`.
- **Defined:**
  - `press_pulse` and `release_pulse` ports exist.
  - Both are generated from a registered copy of `db_out`: press = `prev & ~db_out`, release = `~prev & db_out`, each registered.
- **Undefined:** both ports and the `prev` register are absent. `db_out` behaviour is identical either way.

## Structure
- **Package `pb_debounce_pkg`:**
  - `DEFAULT_CNT_MAX` = 500000
  - `DEFAULT_SYNC_STAGES` = 2
  - `typedef enum logic {STABLE, PENDING} pb_state_t`
- **Sub-module `pb_debounce_chan`:** one channel, holding the synchroniser, counter, FSM and optional pulse logic. The top level generates WIDTH instances of it.

## Test plan
All scenarios use CNT_MAX=8, SYNC_STAGES=2, WIDTH=4 and a 10 ns clock.
- **Reset:** `in_raw`=4'hF during and after reset → `db_out`=4'hF, both pulses 0. Assertions of `reset_n` between edges take effect immediately.
- **Clean press on ch0:** `in_raw`=4'hE held from edge k → `db_out`=4'hE exactly at edge k+9. `press_pulse`=4'h1 for one clock at k+10. Release back to 4'hF → `db_out`=4'hF 9 clocks later and `release_pulse`=4'h1 once.
- **Bounce on ch1:**
  - Stimulus: `in_raw[1]` low 5 clocks, high 2, low 3, high 1, then low 20.
  - Required: `db_out[1]` falls exactly 9 clocks after the final low starts.
  - Required: exactly one `press_pulse[1]`.
  - Required: ch0/2/3 unchanged.
- **Glitch rejection:** `in_raw[2]` low for 7 clocks, then high → `db_out` stays 4'hF and no pulses fire.
- **Simultaneous/staggered presses:** ch2 falls at edge k, ch3 at k+3 → `db_out[2]` falls at k+9 and `db_out[3]` at k+12, with independent pulses.
- **Reset mid-PENDING:**
  - Stimulus: ch0 low for 5 clocks, assert `reset_n`=0 for 2 clocks, deassert with ch0 still low.
  - Required: `db_out`=4'hF during reset, then `db_out[0]` falls 9 clocks after reset deassertion, not earlier.

Source files
------------

// File: rtl/pb_debounce_pkg.sv
// Shared constants and types for the pushbutton debouncer.
package pb_debounce_pkg;

  localparam int DEFAULT_CNT_MAX     = 500000;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } pb_state_t;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: synchroniser, stability counter, 2-state FSM and,
// with PB_DEBOUNCE_EVENT_EN defined, registered press/release pulses.
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int CNT_MAX     = DEFAULT_CNT_MAX,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic db_out
`ifdef PB_DEBOUNCE_EVENT_EN
  ,
  output logic press_pulse,
  output logic release_pulse
`endif
);

  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  pb_state_t              r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;

  pb_state_t              w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_db_nxt;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_db;

  // Input synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_raw};
    end
  end

  // Next-state, counter and output qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    case (r_state)
      STABLE: begin
        if (w_diff) begin
          if (CNT_MAX == 1) begin
            w_db_nxt  = w_sync;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = PENDING;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      PENDING: begin
        if (!w_diff) begin
          // Bounce back to the old level restarts qualification.
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
          w_db_nxt    = w_sync;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
        w_db_nxt    = r_db;
      end
    endcase
  end

  // FSM state, counter and debounced level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_db    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
    end
  end

  assign db_out = r_db;

`ifdef PB_DEBOUNCE_EVENT_EN
  logic r_prev;
  logic r_press;
  logic r_release;

  // Edge detection against the previous debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_prev    <= r_db;
      r_press   <= r_prev & ~r_db;
      r_release <= ~r_prev & r_db;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
`endif

endmodule

// File: rtl/pushbutton_debounce.sv
// Debounces the active-low KEY pins into clean levels for the PIO in_port.
// Optional press/release pulse outputs are enabled by PB_DEBOUNCE_EVENT_EN.
module pushbutton_debounce
  import pb_debounce_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CNT_MAX     = DEFAULT_CNT_MAX,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] db_out
`ifdef PB_DEBOUNCE_EVENT_EN
  ,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
`endif
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    pb_debounce_chan #(
      .CNT_MAX     (CNT_MAX),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_raw        (in_raw[g]),
      .db_out        (db_out[g])
`ifdef PB_DEBOUNCE_EVENT_EN
      ,
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g])
`endif
    );
  end

endmodule
